// File: rtl/z80fi_ld_ind_immed_monitor_pkg.sv
// z80fi_ld_ind_immed_monitor_pkg: opcode constants and expected-write packing for the LD (ind),n monitor
package z80fi_ld_ind_immed_monitor_pkg;
    localparam logic [7:0] OP_LD_HL_N = 8'h36;
    localparam logic [7:0] PFX_IX     = 8'hDD;
    localparam logic [7:0] PFX_IY     = 8'hFD;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_write_t;

    typedef enum logic {T_IDLE, T_WAIT} tmo_state_t;
endpackage

// File: rtl/z80fi_sync_fifo.sv
// z80fi_sync_fifo: synchronous FIFO with wrap-bit pointers and registered count; push and pop may coincide
module z80fi_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_push, do_pop;

    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/z80fi_ld_ind_immed_monitor.sv
// z80fi_ld_ind_immed_monitor: checks retired LD (HL)/(IX+d)/(IY+d),n against snooped bus writes in order
module z80fi_ld_ind_immed_monitor
    import z80fi_ld_ind_immed_monitor_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter bit EN_IX   = 1'b1,
    parameter bit EN_IY   = 1'b1,
    parameter int CNT_W   = 16,
    localparam int PW = $clog2(DEPTH) + 1,
    localparam int TW = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             z80fi_valid,
    input  logic [31:0]      z80fi_insn,
    input  logic [2:0]       z80fi_insn_len,
    input  logic [15:0]      hl_rdata,
    input  logic [15:0]      ix_rdata,
    input  logic [15:0]      iy_rdata,
    input  logic             bus_wr_valid,
    input  logic [15:0]      bus_wr_addr,
    input  logic [7:0]       bus_wr_data,
    output logic [PW-1:0]    pending,
    output logic [CNT_W-1:0] match_count,
    output logic             mismatch,
    output logic             err_mismatch,
    output logic             err_timeout,
    output logic             err_spurious,
    output logic             err_overflow
);
    logic is_hl, is_ix, is_iy, hit;
    logic [15:0] base;
    exp_write_t dec, head, seen;
    logic full, empty, bus_pop, drop, pop, push_ok, same;
    tmo_state_t state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    assign is_hl = z80fi_valid && z80fi_insn_len == 3'd2 && z80fi_insn[7:0] == OP_LD_HL_N;
    assign is_ix = EN_IX && z80fi_valid && z80fi_insn_len == 3'd4
                   && z80fi_insn[7:0] == PFX_IX && z80fi_insn[15:8] == OP_LD_HL_N;
    assign is_iy = EN_IY && z80fi_valid && z80fi_insn_len == 3'd4
                   && z80fi_insn[7:0] == PFX_IY && z80fi_insn[15:8] == OP_LD_HL_N;
    assign hit   = is_hl || is_ix || is_iy;
    assign base  = is_ix ? ix_rdata : iy_rdata;
    // 16-bit add wraps naturally, giving the Z80's modulo-64K effective address
    assign dec.addr = is_hl ? hl_rdata : base + {{8{z80fi_insn[23]}}, z80fi_insn[23:16]};
    assign dec.data = is_hl ? z80fi_insn[15:8] : z80fi_insn[31:24];
    assign seen.addr = bus_wr_addr;
    assign seen.data = bus_wr_data;

    assign bus_pop = bus_wr_valid && !empty;
    assign drop    = state == T_WAIT && tcnt == TW'(TIMEOUT - 1) && !bus_pop;
    assign pop     = bus_pop || drop;
    assign push_ok = hit && (!full || pop);
    assign same    = head == seen;

    z80fi_sync_fifo #(.WIDTH($bits(exp_write_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (hit),
        .pop     (pop),
        .wdata   (dec),
        .rdata   (head),
        .count   (pending),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= T_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = '0;
        state_nxt = state == T_IDLE ? (push_ok ? T_WAIT : T_IDLE)
                  : (pop && pending == PW'(1) && !push_ok ? T_IDLE : T_WAIT);
        tcnt_nxt  = (state == T_IDLE || pop) ? '0 : tcnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            match_count  <= '0;
            mismatch     <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mismatch     <= bus_pop && !same;
            if (bus_pop && same && match_count != '1) match_count <= match_count + 1'b1;
            err_mismatch <= err_mismatch | (bus_pop && !same);
            err_timeout  <= err_timeout | drop;
            err_spurious <= err_spurious | (bus_wr_valid && empty);
            err_overflow <= err_overflow | (hit && full && !pop);
        end
    end
endmodule

// File: tb/tb_z80fi_ld_ind_immed_monitor.sv
// tb_z80fi_ld_ind_immed_monitor: directed plus random stimulus checked against a queue-based reference model
module tb_z80fi_ld_ind_immed_monitor;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        z80fi_valid = 1'b0;
    logic [31:0] z80fi_insn = '0;
    logic [2:0]  z80fi_insn_len = '0;
    logic [15:0] hl_rdata = '0, ix_rdata = '0, iy_rdata = '0;
    logic        bus_wr_valid = 1'b0;
    logic [15:0] bus_wr_addr = '0;
    logic [7:0]  bus_wr_data = '0;
    logic [2:0]  pending;
    logic [15:0] match_count;
    logic        mismatch, err_mismatch, err_timeout, err_spurious, err_overflow;

    z80fi_ld_ind_immed_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .z80fi_valid    (z80fi_valid),
        .z80fi_insn     (z80fi_insn),
        .z80fi_insn_len (z80fi_insn_len),
        .hl_rdata       (hl_rdata),
        .ix_rdata       (ix_rdata),
        .iy_rdata       (iy_rdata),
        .bus_wr_valid   (bus_wr_valid),
        .bus_wr_addr    (bus_wr_addr),
        .bus_wr_data    (bus_wr_data),
        .pending        (pending),
        .match_count    (match_count),
        .mismatch       (mismatch),
        .err_mismatch   (err_mismatch),
        .err_timeout    (err_timeout),
        .err_spurious   (err_spurious),
        .err_overflow   (err_overflow)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] q[$];
    int m_wait = 0;
    int m_match = 0;
    bit m_mis = 0, m_em = 0, m_et = 0, m_es = 0, m_eo = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a queue of expected writes and a count of cycles the head has waited
    task automatic model_step();
        bit hit = 0, popped = 0;
        int a = 0, d = 0, had;
        logic [23:0] e;
        if (!reset_n) begin
            q.delete();
            m_wait = 0; m_match = 0;
            m_mis = 0; m_em = 0; m_et = 0; m_es = 0; m_eo = 0;
            return;
        end
        if (z80fi_valid) begin
            if (z80fi_insn_len == 2 && z80fi_insn[7:0] == 8'h36) begin
                hit = 1; a = hl_rdata; d = z80fi_insn[15:8];
            end else if (z80fi_insn_len == 4 && z80fi_insn[15:8] == 8'h36 &&
                         (z80fi_insn[7:0] == 8'hDD || z80fi_insn[7:0] == 8'hFD)) begin
                int disp = z80fi_insn[23:16];
                if (disp > 127) disp -= 256;
                hit = 1;
                a = ((z80fi_insn[7:0] == 8'hDD ? int'(ix_rdata) : int'(iy_rdata)) + disp + 65536) % 65536;
                d = z80fi_insn[31:24];
            end
        end
        had = q.size();
        m_mis = 0;
        if (bus_wr_valid) begin
            if (had > 0) begin
                e = q.pop_front();
                popped = 1;
                m_wait = 0;
                if (e == {bus_wr_addr, bus_wr_data}) begin
                    if (m_match < 65535) m_match++;
                end else begin
                    m_mis = 1; m_em = 1;
                end
            end else m_es = 1;
        end else if (had > 0 && m_wait == TIMEOUT - 1) begin
            void'(q.pop_front());
            popped = 1; m_wait = 0; m_et = 1;
        end else if (had > 0) m_wait++;
        if (hit) begin
            if (had < DEPTH || popped) q.push_back({a[15:0], d[7:0]});
            else m_eo = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pending", 32'(pending), 32'(q.size()));
        chk("match_count", 32'(match_count), 32'(m_match));
        chk("mismatch", 32'(mismatch), 32'(m_mis));
        chk("err_mismatch", 32'(err_mismatch), 32'(m_em));
        chk("err_timeout", 32'(err_timeout), 32'(m_et));
        chk("err_spurious", 32'(err_spurious), 32'(m_es));
        chk("err_overflow", 32'(err_overflow), 32'(m_eo));
    endtask

    task automatic retire(input logic [31:0] insn, input logic [2:0] len);
        z80fi_valid = 1'b1; z80fi_insn = insn; z80fi_insn_len = len;
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d);
        bus_wr_valid = 1'b1; bus_wr_addr = a; bus_wr_data = d;
    endtask

    task automatic quiet();
        z80fi_valid = 1'b0; bus_wr_valid = 1'b0;
    endtask

    initial begin
        tick();
        reset_n = 1'b1;
        tick();
        // HL form, write two cycles after retirement
        hl_rdata = 16'h1234; retire(32'h0000_5A36, 3'd2); tick();
        chk("tp1_pending", 32'(pending), 32'd1);
        quiet(); tick();
        bus(16'h1234, 8'h5A); tick();
        quiet(); tick();
        chk("tp1_match", 32'(match_count), 32'd1);
        // IX with negative displacement, IY wrapping past FFFF
        ix_rdata = 16'h0005; retire(32'h77FB_36DD, 3'd4); tick();
        quiet(); bus(16'h0000, 8'h77); tick();
        iy_rdata = 16'hFFFF; quiet(); retire(32'h1101_36FD, 3'd4); tick();
        quiet(); bus(16'h0000, 8'h11); tick();
        quiet(); tick();
        chk("tp2_match", 32'(match_count), 32'd3);
        // data mismatch
        hl_rdata = 16'h2000; retire(32'h0000_AA36, 3'd2); tick();
        quiet(); bus(16'h2000, 8'hAB); tick();
        chk("tp3_pulse", 32'(mismatch), 32'd1);
        quiet(); tick();
        chk("tp3_pulse_end", 32'(mismatch), 32'd0);
        chk("tp3_sticky", 32'(err_mismatch), 32'd1);
        // lost write
        retire(32'h0000_0136, 3'd2); tick();
        quiet();
        for (int i = 0; i < TIMEOUT; i++) tick();
        chk("tp4_timeout", 32'(err_timeout), 32'd1);
        chk("tp4_pending", 32'(pending), 32'd0);
        // overflow, then push+pop while full
        for (int i = 0; i < 5; i++) begin
            hl_rdata = 16'h4000 + 16'(i); retire(32'h0000_0036 | (32'(i) << 8), 3'd2); tick();
        end
        chk("tp5_full", 32'(pending), 32'd4);
        chk("tp5_overflow", 32'(err_overflow), 32'd1);
        hl_rdata = 16'h4100; retire(32'h0000_EE36, 3'd2); bus(16'h4000, 8'h00); tick();
        chk("tp5_stay", 32'(pending), 32'd4);
        quiet();
        for (int i = 1; i < 4; i++) begin
            bus(16'h4000 + 16'(i), 8'(i)); tick();
        end
        bus(16'h4100, 8'hEE); tick();
        quiet(); tick();
        // spurious write, then reset with entries queued
        bus(16'h3000, 8'h00); tick();
        quiet(); tick();
        chk("tp6_spurious", 32'(err_spurious), 32'd1);
        retire(32'h0000_1136, 3'd2); tick();
        tick();
        quiet();
        chk("tp6_two", 32'(pending), 32'd2);
        reset_n = 1'b0; tick();
        chk("tp6_rst_pending", 32'(pending), 32'd0);
        chk("tp6_rst_err", 32'({err_mismatch, err_timeout, err_spurious, err_overflow, mismatch}), 32'd0);
        reset_n = 1'b1; tick();
        // random traffic
        for (int i = 0; i < 800; i++) begin
            int f = $urandom_range(0, 3);
            reset_n = $urandom_range(0, 149) != 0;
            z80fi_valid = $urandom_range(0, 2) == 0;
            z80fi_insn = $urandom;
            z80fi_insn_len = 3'($urandom_range(0, 7));
            if (f == 0) begin z80fi_insn[7:0] = 8'h36; z80fi_insn_len = 3'd2; end
            if (f == 1) begin z80fi_insn[15:0] = 16'h36DD; z80fi_insn_len = 3'd4; end
            if (f == 2) begin z80fi_insn[15:0] = 16'h36FD; z80fi_insn_len = 3'd4; end
            hl_rdata = 16'($urandom); ix_rdata = 16'($urandom); iy_rdata = 16'($urandom);
            bus_wr_valid = $urandom_range(0, 2) == 0;
            {bus_wr_addr, bus_wr_data} = 24'($urandom);
            if (q.size() > 0 && $urandom_range(0, 4) != 0) {bus_wr_addr, bus_wr_data} = q[0];
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
